// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, instruction formats and encoder FSM states.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_R      = 7'd51;

    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_R} fmt_e;

    typedef enum logic {ST_IDLE, ST_SECOND} state_e;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I field packer with immediate range check.
module imm_pack
    import rv_pkg::*;
(
    input  logic [6:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  f3_i,
    input  logic [6:0]  f7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    fmt_e fmt;
    logic unknown;

    always_comb begin
        fmt     = FMT_R;
        unknown = 1'b0;
        case (op_i)
            OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_JAL:                   fmt = FMT_J;
            OP_LUI:                   fmt = FMT_U;
            OP_R:                     fmt = FMT_R;
            default:                  unknown = 1'b1;
        endcase
    end

    // Word is always built from the truncated bits; err only flags the loss.
    always_comb begin
        instr_o = {f7_i, rs2_i, rs1_i, f3_i, rd_i, op_i};
        err_o   = unknown;
        case (fmt)
            FMT_I: begin
                instr_o = {imm_i[11:0], rs1_i, f3_i, rd_i, op_i};
                err_o   = imm_i != sext12(imm_i[11:0]);
            end
            FMT_S: begin
                instr_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], op_i};
                err_o   = imm_i != sext12(imm_i[11:0]);
            end
            FMT_B: begin
                instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i,
                           imm_i[4:1], imm_i[11], op_i};
                err_o   = (imm_i != {{19{imm_i[12]}}, imm_i[12:0]}) || imm_i[0];
            end
            FMT_J: begin
                instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
                err_o   = (imm_i != {{11{imm_i[20]}}, imm_i[20:0]}) || imm_i[0];
            end
            FMT_U: begin
                instr_o = {imm_i[31:12], rd_i, op_i};
                err_o   = imm_i[11:0] != 12'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// RV32I instruction encoder with li expansion (addi, lui, or lui+addi) behind
// valid/ready handshakes on both sides and a registered output.
module imm_encoder
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        in_li,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);

    state_e      state_q, state_d;
    logic        valid_q, valid_d, err_q, err_d, last_q, last_d;
    logic [31:0] instr_q, instr_d;
    logic [4:0]  rd_q, rd_d;
    logic [11:0] lo_q, lo_d;

    logic        li_fits, li_two;
    logic [31:0] lui_imm;
    logic [6:0]  pk_op, pk_f7;
    logic [4:0]  pk_rs1, pk_rs2;
    logic [2:0]  pk_f3;
    logic [31:0] pk_imm, pk_instr;
    logic        pk_err;

    // Rounding by 0x800 compensates for the sign of the low addi immediate.
    assign lui_imm = (in_imm + 32'h0000_0800) & 32'hFFFF_F000;
    assign li_fits = in_imm == sext12(in_imm[11:0]);
    assign li_two  = in_li && !li_fits && (in_imm[11:0] != 12'd0);

    always_comb begin
        pk_op  = in_op;
        pk_rs1 = in_rs1;
        pk_rs2 = in_rs2;
        pk_f3  = in_funct3;
        pk_f7  = in_funct7;
        pk_imm = in_imm;
        if (in_li) begin
            pk_rs1 = 5'd0;
            pk_rs2 = 5'd0;
            pk_f3  = 3'd0;
            pk_f7  = 7'd0;
            pk_op  = li_fits ? OP_IMM : OP_LUI;
            pk_imm = li_fits ? in_imm : lui_imm;
        end
    end

    imm_pack u_pack (
        .op_i    (pk_op),
        .rd_i    (in_rd),
        .rs1_i   (pk_rs1),
        .rs2_i   (pk_rs2),
        .f3_i    (pk_f3),
        .f7_i    (pk_f7),
        .imm_i   (pk_imm),
        .instr_o (pk_instr),
        .err_o   (pk_err)
    );

    assign in_ready = (state_q == ST_IDLE) && (!valid_q || out_ready);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q && !out_ready;
        instr_d = instr_q;
        err_d   = err_q;
        last_d  = last_q;
        rd_d    = rd_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    valid_d = 1'b1;
                    instr_d = pk_instr;
                    err_d   = pk_err && !in_li;
                    last_d  = !li_two;
                    if (li_two) begin
                        state_d = ST_SECOND;
                        rd_d    = in_rd;
                        lo_d    = in_imm[11:0];
                    end
                end
            end
            ST_SECOND: begin
                // valid_q is always set here, so out_ready means the lui handshakes.
                if (out_ready) begin
                    valid_d = 1'b1;
                    instr_d = {lo_q, rd_q, 3'b000, rd_q, OP_IMM};
                    err_d   = 1'b0;
                    last_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            rd_q    <= 5'd0;
            lo_q    <= 12'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            lo_q    <= lo_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed requests push expected words,
// an independent monitor pops and compares on every output handshake.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        in_li = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic        out_last;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        last;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .in_li     (in_li),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares every word that handshakes against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", out_instr, 32'hDEAD_BEEF);
                end else begin
                    e = sb.pop_front();
                    chk("instr", out_instr, e.instr);
                    chk("err", 32'(out_err), 32'(e.err));
                    chk("last", 32'(out_last), 32'(e.last));
                    if (e.due >= 0) chk("latency", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input logic li, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] e0, input logic e0_err, input logic two,
                        input logic [31:0] e1, input logic lat);
        exp_t e;
        int   n;
        in_valid = 1'b1; in_li = li; in_op = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        e.instr = e0; e.err = e0_err; e.last = !two; e.due = lat ? cyc + 1 : -1;
        sb.push_back(e);
        if (two) begin
            e.instr = e1; e.err = 1'b0; e.last = 1'b1; e.due = -1;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk); n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(negedge clk);

        // addi x5, x0, -1
        send(0, 7'd19, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0293, 0, 0, 0, 1);
        // sw then beq back-to-back
        send(0, 7'd35, 5'd0, 5'd2, 5'd6, 3'd2, 7'd0, 32'd8, 32'h0061_2423, 0, 0, 0, 1);
        send(0, 7'd99, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 0, 0, 0, 1);
        // jal x1, 2048 and misaligned 2049
        send(0, 7'd111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 0, 0, 0, 1);
        send(0, 7'd111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2049, 32'h0010_00EF, 1, 0, 0, 1);
        // I-format out of range, U-format low bits set
        send(0, 7'd19, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0013, 1, 0, 0, 1);
        send(0, 7'd55, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 32'h0000_11B7, 1, 0, 0, 1);
        // sub x1, x2, x3 and the same fields under an unknown opcode
        send(0, 7'd51, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 32'h4031_00B3, 0, 0, 0, 1);
        send(0, 7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 32'h4031_00FF, 1, 0, 0, 1);
        // li single-word forms, including the -2048 boundary
        send(1, 7'd0, 5'd7, 5'd9, 5'd9, 3'd7, 7'd0, 32'hFFFF_FFFB, 32'hFFB0_0393, 0, 0, 0, 1);
        send(1, 7'd0, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0213, 0, 0, 0, 1);
        send(1, 7'd0, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_5137, 0, 0, 0, 1);
        // li 2048: just outside addi range, needs lui 1 + addi -2048
        send(1, 7'd0, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0000_1237, 0, 1, 32'h8002_0213, 0);
        drain();

        // Two-word li under backpressure
        out_ready = 1'b0;
        send(1, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 32'h1234_6537, 0, 1, 32'hFFF5_0513, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_lui_instr", out_instr, 32'h1234_6537);
            chk("bp_lui_last", 32'(out_last), 32'd0);
            chk("second_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_addi_instr", out_instr, 32'hFFF5_0513);
            chk("bp_addi_last", 32'(out_last), 32'd1);
            @(negedge clk);
        end
        drain();

        // Reset while the second word is pending
        out_ready = 1'b0;
        send(1, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 32'h1234_6537, 0, 1, 32'hFFF5_0513, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_instr", out_instr, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("no_addi_after_rst", 32'(out_valid), 32'd0);
        end
        @(negedge clk);

        // Normal operation resumes
        send(0, 7'd19, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0293, 0, 0, 0, 1);
        drain();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
